// File: rtl/alu_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter_pkg
// Description : Shared ALU definitions: opcode width and encodings, arbiter
//               state encoding, default ack timeout, index-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_arbiter_pkg;

    // ALU opcode field width and encodings
    localparam int ALU_OP_W = 5;

    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 5'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 5'd1;
    localparam logic [ALU_OP_W-1:0] ALU_AND  = 5'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OR   = 5'd3;
    localparam logic [ALU_OP_W-1:0] ALU_XOR  = 5'd4;
    localparam logic [ALU_OP_W-1:0] ALU_SLL  = 5'd5;
    localparam logic [ALU_OP_W-1:0] ALU_SRL  = 5'd6;
    localparam logic [ALU_OP_W-1:0] ALU_SRA  = 5'd7;
    localparam logic [ALU_OP_W-1:0] ALU_SLT  = 5'd8;
    localparam logic [ALU_OP_W-1:0] ALU_SLTU = 5'd9;

    // Cycles to wait for alu_ack before giving up on an operation
    localparam int ARB_TO_CYC_DEF = 64;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    // Width of an index into n requesters (at least one bit)
    function automatic int arb_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter_rr_pick
// Description : Combinational round-robin selector. Scans the request vector
//               upward starting just after the last granted index, wrapping
//               modulo N_REQ, and returns the winner one-hot and as an index.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter_rr_pick
    import alu_arbiter_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IDX_W = arb_idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [N_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    int w_cand;

    // First set request after i_last wins; i_last itself is checked last
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_cand = (int'(i_last) + k) % N_REQ;
            if (!o_valid && i_req[w_cand]) begin
                o_valid       = 1'b1;
                o_gnt[w_cand] = 1'b1;
                o_idx         = w_cand[IDX_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Shares one ALU between N_REQ requesters. Round-robin grant,
//               operand latch at grant, run/ack handshake with timeout, and a
//               one-cycle done pulse returning the result to the winner.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int REG_SZ = 32,
    parameter int N_REQ  = 2,
    parameter int OP_W   = ALU_OP_W,
    parameter int TO_CYC = ARB_TO_CYC_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*OP_W-1:0]   req_op,
    input  logic [N_REQ*REG_SZ-1:0] req_opr1,
    input  logic [N_REQ*REG_SZ-1:0] req_opr2,
    input  logic [N_REQ-1:0]        req_c,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        done,
    output logic [REG_SZ-1:0]       res,
    output logic                    err,
    output logic                    alu_run,
    output logic [OP_W-1:0]         alu_op,
    output logic [REG_SZ-1:0]       alu_opr1,
    output logic [REG_SZ-1:0]       alu_opr2,
    output logic                    alu_c,
    input  logic [REG_SZ-1:0]       alu_ans,
    input  logic                    alu_ack,
    output logic                    busy
);

    localparam int              IDX_W    = arb_idx_w(N_REQ);
    localparam int              CNT_W    = $clog2(TO_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

    arb_state_t         r_state,  w_state_nxt;
    logic [IDX_W-1:0]   r_last,   w_last_nxt;
    logic [CNT_W-1:0]   r_cnt,    w_cnt_nxt;
    logic [N_REQ-1:0]   r_gnt,    w_gnt_nxt;
    logic [N_REQ-1:0]   r_done,   w_done_nxt;
    logic               r_err,    w_err_nxt;
    logic [REG_SZ-1:0]  r_res,    w_res_nxt;
    logic               r_run,    w_run_nxt;
    logic [OP_W-1:0]    r_op,     w_op_nxt;
    logic [REG_SZ-1:0]  r_opr1,   w_opr1_nxt;
    logic [REG_SZ-1:0]  r_opr2,   w_opr2_nxt;
    logic               r_c,      w_c_nxt;

    logic [N_REQ-1:0]   w_pick_gnt;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_valid;

    alu_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_req   (req),
        .i_last  (r_last),
        .o_gnt   (w_pick_gnt),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    // Next-state and next-register values for the sequencing FSM
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        w_gnt_nxt   = r_gnt;
        w_done_nxt  = '0;
        w_err_nxt   = 1'b0;
        w_res_nxt   = r_res;
        w_run_nxt   = r_run;
        w_op_nxt    = r_op;
        w_opr1_nxt  = r_opr1;
        w_opr2_nxt  = r_opr2;
        w_c_nxt     = r_c;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_op_nxt    = req_op[int'(w_pick_idx)*OP_W +: OP_W];
                    w_opr1_nxt  = req_opr1[int'(w_pick_idx)*REG_SZ +: REG_SZ];
                    w_opr2_nxt  = req_opr2[int'(w_pick_idx)*REG_SZ +: REG_SZ];
                    w_c_nxt     = req_c[w_pick_idx];
                    w_gnt_nxt   = w_pick_gnt;
                    w_last_nxt  = w_pick_idx;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // A lingering ack from the previous op must fall before the
                // next run edge, otherwise the ALU cannot see a fresh start.
                if (!alu_ack) begin
                    w_run_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (alu_ack) begin
                    w_res_nxt   = alu_ans;
                    w_run_nxt   = 1'b0;
                    w_done_nxt  = r_gnt;
                    w_state_nxt = ST_DONE;
                end else if (r_cnt == CNT_LAST) begin
                    w_res_nxt   = '0;
                    w_err_nxt   = 1'b1;
                    w_run_nxt   = 1'b0;
                    w_done_nxt  = r_gnt;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            ST_DONE: begin
                // Requests are not sampled here so the winner has a cycle to
                // drop req after seeing done.
                w_gnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation silently
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_last  <= IDX_LAST;
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_err   <= 1'b0;
            r_res   <= '0;
            r_run   <= 1'b0;
            r_op    <= '0;
            r_opr1  <= '0;
            r_opr2  <= '0;
            r_c     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gnt   <= w_gnt_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            r_res   <= w_res_nxt;
            r_run   <= w_run_nxt;
            r_op    <= w_op_nxt;
            r_opr1  <= w_opr1_nxt;
            r_opr2  <= w_opr2_nxt;
            r_c     <= w_c_nxt;
        end
    end

    assign gnt      = r_gnt;
    assign done     = r_done;
    assign res      = r_res;
    assign err      = r_err;
    assign alu_run  = r_run;
    assign alu_op   = r_op;
    assign alu_opr1 = r_opr1;
    assign alu_opr2 = r_opr2;
    assign alu_c    = r_c;
    assign busy     = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Directed self-checking bench for alu_arbiter with a small
//               behavioural ALU (configurable ack delay, no-ack, sticky ack).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int REG_SZ = 32;
    localparam int N_REQ  = 2;
    localparam int OP_W   = ALU_OP_W;
    localparam int TO_CYC = 8;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic [N_REQ-1:0]        req = '0;
    logic [N_REQ*OP_W-1:0]   req_op = '0;
    logic [N_REQ*REG_SZ-1:0] req_opr1 = '0;
    logic [N_REQ*REG_SZ-1:0] req_opr2 = '0;
    logic [N_REQ-1:0]        req_c = '0;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        done;
    logic [REG_SZ-1:0]       res;
    logic                    err;
    logic                    alu_run;
    logic [OP_W-1:0]         alu_op;
    logic [REG_SZ-1:0]       alu_opr1;
    logic [REG_SZ-1:0]       alu_opr2;
    logic                    alu_c;
    logic [REG_SZ-1:0]       alu_ans;
    logic                    alu_ack;
    logic                    busy;

    int n_checks = 0;
    int n_fail   = 0;

    // ALU model controls
    int ack_delay    = 3;
    int sticky_extra = 0;
    bit never_ack    = 1'b0;
    int m_cnt;
    int m_hold;

    alu_arbiter #(
        .REG_SZ (REG_SZ),
        .N_REQ  (N_REQ),
        .OP_W   (OP_W),
        .TO_CYC (TO_CYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_op   (req_op),
        .req_opr1 (req_opr1),
        .req_opr2 (req_opr2),
        .req_c    (req_c),
        .gnt      (gnt),
        .done     (done),
        .res      (res),
        .err      (err),
        .alu_run  (alu_run),
        .alu_op   (alu_op),
        .alu_opr1 (alu_opr1),
        .alu_opr2 (alu_opr2),
        .alu_c    (alu_c),
        .alu_ans  (alu_ans),
        .alu_ack  (alu_ack),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: acks ack_delay cycles after run rises, keeps ack for
    // sticky_extra cycles after run falls, or never acks when never_ack is set
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_ack <= 1'b0;
            alu_ans <= '0;
            m_cnt   <= 0;
            m_hold  <= 0;
        end else if (alu_run && !alu_ack) begin
            if (!never_ack) begin
                if (m_cnt == ack_delay - 1) begin
                    alu_ack <= 1'b1;
                    alu_ans <= (alu_op == ALU_SUB) ? (alu_opr1 - alu_opr2)
                                                   : (alu_opr1 + alu_opr2 + {31'b0, alu_c});
                    m_cnt   <= 0;
                    m_hold  <= sticky_extra;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end
        end else if (!alu_run && alu_ack) begin
            if (m_hold == 0) alu_ack <= 1'b0;
            else             m_hold  <= m_hold - 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [OP_W-1:0] op,
                           input logic [REG_SZ-1:0] a, input logic [REG_SZ-1:0] b,
                           input logic c);
        req_op[i*OP_W +: OP_W]       = op;
        req_opr1[i*REG_SZ +: REG_SZ] = a;
        req_opr2[i*REG_SZ +: REG_SZ] = b;
        req_c[i]                     = c;
    endtask

    // which: 0 = alu_run high, 1 = done pulse, 2 = grant; n = edges elapsed,
    // 0 if the budget expired
    task automatic wait_for(input int which, input int budget, output int n);
        n = 0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if ((which == 0 && alu_run) || (which == 1 && done != '0) ||
                (which == 2 && gnt != '0)) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        int  stall;
        bit  rose;
        bit  ack_at_run;
        bit  saw_done;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_gnt",  gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_run",  alu_run, 0);
        chk("rst_err",  err, 0);
        rst = 1'b1;
        @(negedge clk);

        // Single request: 5 + 7
        set_req(0, ALU_ADD, 32'd5, 32'd7, 1'b0);
        req = 2'b01;
        wait_for(0, 10, n);
        chk("t1_run_lat", n, 2);
        chk("t1_gnt", gnt, 1);
        chk("t1_opr2", alu_opr2, 7);
        wait_for(1, 20, n);
        chk("t1_done_lat", n, 4);
        chk("t1_done", done, 1);
        chk("t1_res", res, 12);
        chk("t1_err", err, 0);
        req = '0;
        @(negedge clk);
        chk("t1_busy_after", busy, 0);
        chk("t1_done_after", done, 0);
        chk("t1_res_held", res, 12);

        // Simultaneous requests held high: grants alternate 0,1,0,1
        do_reset();
        set_req(0, ALU_ADD, 32'd1,  32'd2, 1'b0);
        set_req(1, ALU_SUB, 32'd50, 32'd8, 1'b0);
        req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_for(1, 30, n);
            chk("t2_seen", n != 0, 1);
            chk("t2_done", done, (k % 2 == 0) ? 1 : 2);
            chk("t2_res",  res,  (k % 2 == 0) ? 3 : 42);
        end
        req = '0;
        @(negedge clk);

        // Operand stability: opr1 changes after grant
        do_reset();
        set_req(1, ALU_ADD, 32'd3, 32'd4, 1'b0);
        req = 2'b10;
        wait_for(2, 10, n);
        chk("t3_gnt_lat", n, 1);
        chk("t3_gnt", gnt, 2);
        @(negedge clk);
        req_opr1[REG_SZ +: REG_SZ] = 32'd9;
        wait_for(1, 20, n);
        chk("t3_done", done, 2);
        chk("t3_opr1", alu_opr1, 3);
        chk("t3_res", res, 7);
        req = '0;
        @(negedge clk);

        // Timeout: ALU never acks
        never_ack = 1'b1;
        set_req(0, ALU_ADD, 32'd1, 32'd1, 1'b0);
        req = 2'b01;
        wait_for(0, 10, n);
        chk("t4_run_lat", n, 2);
        wait_for(1, 30, n);
        chk("t4_to_lat", n, TO_CYC);
        chk("t4_err", err, 1);
        chk("t4_done", done, 1);
        chk("t4_res", res, 0);
        req = '0;
        @(negedge clk);
        chk("t4_err_pulse", err, 0);
        chk("t4_busy", busy, 0);
        never_ack = 1'b0;
        set_req(0, ALU_ADD, 32'd2, 32'd2, 1'b0);
        req = 2'b01;
        wait_for(1, 30, n);
        chk("t4_next_done", done, 1);
        chk("t4_next_res", res, 4);
        chk("t4_next_err", err, 0);
        req = '0;
        @(negedge clk);

        // Reset in the middle of WAIT
        ack_delay = 20;
        set_req(0, ALU_ADD, 32'd8, 32'd8, 1'b0);
        req = 2'b01;
        wait_for(0, 10, n);
        chk("t5_run_seen", n != 0, 1);
        @(negedge clk);
        chk("t5_busy_pre", busy, 1);
        rst = 1'b0;
        req = '0;
        #1;
        chk("t5_gnt", gnt, 0);
        chk("t5_busy", busy, 0);
        chk("t5_run", alu_run, 0);
        chk("t5_res", res, 0);
        chk("t5_opr1", alu_opr1, 0);
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done != '0) saw_done = 1'b1;
        end
        chk("t5_no_done", saw_done, 0);
        rst = 1'b1;
        ack_delay = 3;
        set_req(1, ALU_ADD, 32'd20, 32'd22, 1'b1);
        req = 2'b10;
        wait_for(2, 10, n);
        chk("t5_gnt_lat", n, 1);
        chk("t5_gnt_after", gnt, 2);
        wait_for(1, 20, n);
        chk("t5_done", done, 2);
        chk("t5_res_after", res, 43);
        req = '0;
        @(negedge clk);

        // Sticky ack: new request waits in ISSUE until ack falls
        sticky_extra = 3;
        set_req(0, ALU_ADD, 32'd6, 32'd7, 1'b0);
        req = 2'b01;
        wait_for(1, 30, n);
        chk("t6_res0", res, 13);
        set_req(1, ALU_ADD, 32'd100, 32'd23, 1'b1);
        req = 2'b10;
        stall = 0;
        rose = 1'b0;
        ack_at_run = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gnt == 2'b10 && alu_ack && !alu_run) stall++;
            if (alu_run) begin
                rose = 1'b1;
                ack_at_run = alu_ack;
                break;
            end
        end
        chk("t6_stall", stall, 2);
        chk("t6_run_rose", rose, 1);
        chk("t6_ack_at_run", ack_at_run, 0);
        wait_for(1, 20, n);
        chk("t6_done", done, 2);
        chk("t6_res1", res, 124);
        req = '0;
        sticky_extra = 0;
        repeat (6) @(negedge clk);
        chk("t6_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
